ahb_sram_responder: RTL and testbench
=====================================

// Module: ahb_sram_responder
// PURPOSE
// - AHB-Lite subordinate (responder) with a word-organised SRAM; the far end of the core's data/instruction AHB master ports.
// - Checks the custom write checksum and, optionally, the address-phase parity; returns a SEC-DED checksum with every read.
// - Used as TCM/boot RAM in SoC integration and as the memory model in core-level benches.
// PARAMETERS
// - MEM_WORDS    1024  number of 32-bit words; legal byte addresses 0 .. MEM_WORDS*4-1
// - WAIT_STATES  0     data-phase wait cycles (0..15) inserted before an OKAY completion
// PORTS
// - s_clk_i          in   1   clock, rising edge
// - s_reset_i        in   1   asynchronous, active-high reset
// - s_hsel_i         in   1   responder select
// - s_hready_i       in   1   bus HREADY; an address phase is accepted only when high
// - s_haddr_i        in   32  address
// - s_htrans_i       in   2   transfer type (IDLE/BUSY ignored, NONSEQ/SEQ accepted)
// - s_hsize_i        in   3   transfer size (0 byte, 1 half, 2 word)
// - s_hwrite_i       in   1   write indicator
// - s_hwdata_i       in   32  write data (data phase)
// - s_hwchecksum_i   in   7   (39,32) SEC-DED checksum of s_hwdata_i (data phase)
// - s_hparity_i      in   6   address-phase control parity
// - s_hrdata_o       out  32  read data
// - s_hrchecksum_o   out  7   (39,32) SEC-DED checksum of s_hrdata_o
// - s_hready_o       out  1   HREADYOUT
// - s_hresp_o        out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
// - Reset: state IDLE; s_hready_o=1, s_hresp_o=0, s_hrdata_o=0, s_hrchecksum_o=0. SRAM contents not cleared.
// - Accept: s_hsel_i & s_hready_i & s_htrans_i[1]; register addr, size, write, error flags; enter DATA.
// - Address error at accept: addr >= MEM_WORDS*4, hsize>2, misaligned (half with addr[0], word with addr[1:0]!=0).
// - FSM: IDLE -> DATA on accept. DATA: wait counter loaded with WAIT_STATES; s_hready_o=0 while counter!=0, decrements each cycle.
//   At counter==0: if error pending -> ERR1, else s_hready_o=1, OKAY, transfer completes;
//   back-to-back accept in that same cycle -> DATA again, otherwise -> IDLE.
// - ERR1: s_hready_o=0, s_hresp_o=1 -> ERR2. ERR2: s_hready_o=1, s_hresp_o=1; accept allowed, -> DATA or IDLE.
// - Address errors skip wait states: DATA goes to ERR1 in its first cycle.
// - Write: in the completing DATA cycle, recompute the checksum of s_hwdata_i.
//   Mismatch with s_hwchecksum_i -> ERR1, no write.
//   Match -> write the selected byte lanes (per hsize/addr[1:0]) at that clock edge.
// - Read: s_hrdata_o = mem[addr_q[..:2]] (full word, all lanes) during DATA of a read; 0 otherwise.
//   s_hrchecksum_o = encode(s_hrdata_o), combinational.
// - Read immediately after write to the same word returns the new data (write commits at the edge ending the write data phase).
// - Reset asserted mid-transfer: immediate return to IDLE/reset outputs; an uncommitted write is dropped.
// CONFIGURATION
// - AHB_PARITY_CHECK_EN defined: at accept, compare s_hparity_i with:
//   [3:0] = XOR of each haddr byte (bit n covers haddr[8n+7:8n]), [4] = ^{hwrite,hsize}, [5] = ^htrans.
//   Any mismatch is an address error (ERROR response, no access).
// - Undefined: s_hparity_i ignored; no parity logic synthesised.
// TESTING
// - WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 -> hrdata 0xDEADBEEF, hrchecksum=encode(0xDEADBEEF), OKAY, no stall.
// - Byte write 0xAA @0x13 over 0x11223344 @0x10 -> read @0x10 returns 0xAA223344.
// - WAIT_STATES=2: read -> s_hready_o low exactly 2 cycles, then high with OKAY and valid data.
// - Read @MEM_WORDS*4 or word @0x2 -> ERR1 (hready 0, hresp 1), ERR2 (hready 1, hresp 1); next access OKAY.
// - Write 0x12345678 with checksum bit0 flipped -> two-cycle ERROR; subsequent read returns old contents.
// - Macro on: flip s_hparity_i[4] on a valid read -> ERROR. Macro off: same stimulus -> OKAY.
// - Assert s_reset_i during a wait state -> outputs at reset values next cycle; prior contents of the target word unchanged.

Source files
------------

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder with (39,32) SEC-DED write checking and read checksum generation.
// Optional address-phase parity checking is built when AHB_PARITY_CHECK_EN is defined.
module ahb_sram_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic        s_hready_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic [2:0]  s_hsize_i,
    input  logic        s_hwrite_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwchecksum_i,
    input  logic [5:0]  s_hparity_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hready_o,
    output logic        s_hresp_o
);

    // state | meaning
    // IDLE  | no data phase outstanding
    // DATA  | data phase: wait states, then OKAY completion or error detection
    // ERR1  | first ERROR cycle (hready low)
    // ERR2  | second ERROR cycle (hready high, may accept next transfer)
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    // Check bits: [5:0] = XOR of the Hamming positions (non-powers of two, 3..38,
    // ascending) of all set data bits; [6] = overall parity of data and [5:0].
    function automatic logic [6:0] secded_enc(input logic [31:0] d);
        logic [6:0]  c;
        logic [5:0]  pos;
        int unsigned j;
        c = '0;
        j = 0;
        for (int unsigned p = 3; p < 39; p++) begin
            pos = 6'(p);
            if ((pos & (pos - 6'd1)) != 6'd0) begin
                if (d[j[4:0]]) c[5:0] = c[5:0] ^ pos;
                j = j + 1;
            end
        end
        c[6] = ^{d, c[5:0]};
        return c;
    endfunction

    state_t          state_q, state_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;
    logic            err_q, err_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [31:0]     mem [MEM_WORDS];
    logic [31:0]     rd_word;
    logic            accept;
    logic            take;
    logic            addr_err;
    logic            csum_ok;
    logic            mem_we;
    logic [3:0]      be;

    assign accept  = s_hsel_i & s_hready_i & s_htrans_i[1];
    assign csum_ok = (secded_enc(s_hwdata_i) == s_hwchecksum_i);
    assign rd_word = mem[addr_q[AW+1:2]];

`ifdef AHB_PARITY_CHECK_EN
    logic [5:0] par_exp;
    assign par_exp = {^s_htrans_i, ^{s_hwrite_i, s_hsize_i},
                      ^s_haddr_i[31:24], ^s_haddr_i[23:16], ^s_haddr_i[15:8], ^s_haddr_i[7:0]};
`else
    logic unused_parity_in;
    assign unused_parity_in = ^{s_hparity_i, s_htrans_i[0]};
`endif

    always_comb begin
        addr_err = 1'b0;
        if ({1'b0, s_haddr_i} >= MEM_BYTES)                addr_err = 1'b1;
        if (s_hsize_i > 3'd2)                              addr_err = 1'b1;
        if (s_hsize_i == 3'd1 && s_haddr_i[0])             addr_err = 1'b1;
        if (s_hsize_i == 3'd2 && s_haddr_i[1:0] != 2'b00)  addr_err = 1'b1;
`ifdef AHB_PARITY_CHECK_EN
        if (s_hparity_i != par_exp)                        addr_err = 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        s_hready_o = 1'b1;
        s_hresp_o  = 1'b0;
        mem_we     = 1'b0;
        take       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take = accept;
            end
            ST_DATA: begin
                if (err_q) begin
                    s_hready_o = 1'b0;
                    state_d    = ST_ERR1;
                end else if (cnt_q != 4'd0) begin
                    s_hready_o = 1'b0;
                    cnt_d      = cnt_q - 4'd1;
                end else if (write_q && !csum_ok) begin
                    s_hready_o = 1'b0;
                    state_d    = ST_ERR1;
                end else begin
                    mem_we  = write_q;
                    take    = accept;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                s_hready_o = 1'b0;
                s_hresp_o  = 1'b1;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                s_hresp_o = 1'b1;
                take      = accept;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            state_d = ST_DATA;
            addr_d  = s_haddr_i[AW+1:0];
            size_d  = s_hsize_i[1:0];
            write_d = s_hwrite_i;
            err_d   = addr_err;
            cnt_d   = 4'(WAIT_STATES);
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // SRAM is deliberately not reset; writes are gated by the reset-cleared state.
    always_ff @(posedge s_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= s_hwdata_i[8*b +: 8];
            end
        end
    end

    assign s_hrdata_o     = (state_q == ST_DATA && !write_q && !err_q) ? rd_word : 32'd0;
    assign s_hrchecksum_o = secded_enc(s_hrdata_o);

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Scoreboard bench for ahb_sram_responder: two instances (0 and 2 wait states) on a shared
// pipelined AHB driver, checked against a byte-level memory model and textbook Hamming encoder.
module tb_ahb_sram_responder;
    localparam int MW = 1024;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        bad_csum;
        logic        bad_par;
    } txn_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0, tgt = 1'b0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic [6:0]  hwcs = '0;
    logic [5:0]  hpar = '0;
    logic [31:0] rd0, rd2;
    logic [6:0]  rc0, rc2;
    logic        rdy0, rdy2, rsp0, rsp2;
    logic        hsel0, hsel2, hready_m, hresp_m;
    logic [31:0] hrdata_m;
    logic [6:0]  hrc_m;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    txn_t pend[$];
    exp_t expq[$];
    logic [31:0] mdl [2][MW];

    always #5 clk = ~clk;

    assign hsel0    = hsel & ~tgt;
    assign hsel2    = hsel & tgt;
    assign hready_m = tgt ? rdy2 : rdy0;
    assign hresp_m  = tgt ? rsp2 : rsp0;
    assign hrdata_m = tgt ? rd2 : rd0;
    assign hrc_m    = tgt ? rc2 : rc0;

    ahb_sram_responder #(.MEM_WORDS(MW), .WAIT_STATES(0)) u_ws0 (
        .s_clk_i(clk), .s_reset_i(rst), .s_hsel_i(hsel0), .s_hready_i(rdy0),
        .s_haddr_i(haddr), .s_htrans_i(htrans), .s_hsize_i(hsize), .s_hwrite_i(hwrite),
        .s_hwdata_i(hwdata), .s_hwchecksum_i(hwcs), .s_hparity_i(hpar),
        .s_hrdata_o(rd0), .s_hrchecksum_o(rc0), .s_hready_o(rdy0), .s_hresp_o(rsp0));

    ahb_sram_responder #(.MEM_WORDS(MW), .WAIT_STATES(2)) u_ws2 (
        .s_clk_i(clk), .s_reset_i(rst), .s_hsel_i(hsel2), .s_hready_i(rdy2),
        .s_haddr_i(haddr), .s_htrans_i(htrans), .s_hsize_i(hsize), .s_hwrite_i(hwrite),
        .s_hwdata_i(hwdata), .s_hwchecksum_i(hwcs), .s_hparity_i(hpar),
        .s_hrdata_o(rd2), .s_hrchecksum_o(rc2), .s_hready_o(rdy2), .s_hresp_o(rsp2));

    // Textbook Hamming: data fills codeword positions 1..38 skipping powers of two;
    // check bit b is the parity of every position with bit b set; bit 6 is overall parity.
    function automatic logic [6:0] ref_enc(input logic [31:0] d);
        logic       cw [39];
        logic [6:0] r;
        int         k;
        k = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) cw[p] = 1'b0;
            else begin cw[p] = d[k]; k++; end
        end
        r = '0;
        for (int b = 0; b < 6; b++)
            for (int p = 1; p <= 38; p++)
                if ((p & (1 << b)) != 0) r[b] = r[b] ^ cw[p];
        r[6] = ^d ^ (^r[5:0]);
        return r;
    endfunction

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d, input logic bc, input logic bp);
        txn_t t;
        t.wr = wr; t.addr = a; t.size = s; t.wdata = d; t.bad_csum = bc; t.bad_par = bp;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic abort_run(input string why);
        failures++;
        $display("FAIL %s: bound expired at t=%0t", why, $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Reference model: decides the response from the transfer rules and updates byte lanes.
    task automatic issue(input txn_t t);
        exp_t e;
        logic err;
        int   ws, w, lane;
        ws  = tgt ? 2 : 0;
        err = (t.addr >= MW * 4) || (t.size > 3'd2) ||
              (t.size == 3'd1 && t.addr % 2 != 0) || (t.size == 3'd2 && t.addr % 4 != 0);
`ifdef AHB_PARITY_CHECK_EN
        if (t.bad_par) err = 1'b1;
`endif
        e.rdata = 32'd0;
        if (err) begin
            e.resp = 1'b1; e.stalls = 2;
        end else if (t.wr && t.bad_csum) begin
            e.resp = 1'b1; e.stalls = ws + 2;
        end else begin
            e.resp = 1'b0; e.stalls = ws;
            w = int'(t.addr / 4);
            if (t.wr) begin
                for (int k = 0; k < (1 << t.size); k++) begin
                    lane = int'(t.addr % 4) + k;
                    mdl[tgt][w][8*lane +: 8] = t.wdata[8*lane +: 8];
                end
            end else e.rdata = mdl[tgt][w];
        end
        expq.push_back(e);
    endtask

    task automatic drive_addr(input txn_t t);
        hsel   = 1'b1;
        htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        haddr  = t.addr;
        hsize  = t.size;
        hwrite = t.wr;
        hpar   = {^htrans, ^{hwrite, hsize}, ^haddr[31:24], ^haddr[23:16], ^haddr[15:8], ^haddr[7:0]};
        if (t.bad_par) hpar[4] = ~hpar[4];
    endtask

    task automatic drive_idle(input logic sel);
        hsel   = sel;
        htrans = {1'b0, 1'($urandom_range(0, 1))};
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'd2;
        hpar   = '0;
    endtask

    task automatic run_queue();
        txn_t cur, prev;
        bit   have_prev, have_cur;
        int   guard;
        have_prev = 1'b0;
        while (have_prev || pend.size() != 0) begin
            @(negedge clk);
            if (have_prev && prev.wr) begin
                hwdata = prev.wdata;
                hwcs   = ref_enc(prev.wdata) ^ {6'd0, prev.bad_csum};
            end else begin
                hwdata = $urandom;
                hwcs   = 7'($urandom);
            end
            have_cur = 1'b0;
            if (pend.size() != 0 && $urandom_range(0, 4) != 0) begin
                cur = pend.pop_front();
                drive_addr(cur);
                issue(cur);
                have_cur = 1'b1;
            end else drive_idle(1'($urandom_range(0, 1)));
            #1;
            guard = 0;
            while (!hready_m) begin
                @(negedge clk); #1;
                guard++;
                if (guard > 40) abort_run("hready_timeout");
            end
            prev = cur;
            have_prev = have_cur;
        end
        @(negedge clk);
        drive_idle(1'b0);
    endtask

    // Monitor: follows data phases on the bus and compares each completion with the scoreboard.
    initial begin
        bit   in_data, last_resp;
        int   stalls;
        exp_t e;
        in_data = 1'b0; last_resp = 1'b0; stalls = 0;
        forever begin
            @(negedge clk); #3;
            if (!mon_en) in_data = 1'b0;
            else begin
                if (in_data) begin
                    if (hready_m) begin
                        if (expq.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
                        else begin
                            e = expq.pop_front();
                            check("hresp", {31'd0, hresp_m}, {31'd0, e.resp});
                            check("hrdata", hrdata_m, e.rdata);
                            check("hrchecksum", {25'd0, hrc_m}, {25'd0, ref_enc(e.rdata)});
                            check("stall_cycles", 32'(stalls), 32'(e.stalls));
                            check("stall_resp", {31'd0, last_resp}, {31'd0, e.resp});
                        end
                        in_data = 1'b0;
                    end else begin
                        stalls++;
                        last_resp = hresp_m;
                    end
                end
                if (hsel && hready_m && htrans[1]) begin
                    in_data = 1'b1; stalls = 0; last_resp = 1'b0;
                end
            end
        end
    end

    initial begin
        txn_t t;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        check("rst_hready0", {31'd0, rdy0}, 32'd1);
        check("rst_hresp0", {31'd0, rsp0}, 32'd0);
        check("rst_hrdata0", rd0, 32'd0);
        check("rst_hrcs0", {25'd0, rc0}, 32'd0);
        check("rst_hready2", {31'd0, rdy2}, 32'd1);
        check("rst_hrdata2", rd2, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Zero-wait instance: directed cases
        tgt = 1'b0;
        pend.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0));
        pend.push_back(mk(0, 32'h10, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(1, 32'h10, 3'd2, 32'h11223344, 0, 0));
        pend.push_back(mk(1, 32'h13, 3'd0, 32'hAA000000, 0, 0));
        pend.push_back(mk(0, 32'h10, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(0, 32'(MW * 4), 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(0, 32'h2, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(0, 32'h10, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(1, 32'h10, 3'd2, 32'h12345678, 1, 0));
        pend.push_back(mk(0, 32'h10, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(0, 32'h10, 3'd2, 32'h0, 0, 1));
        pend.push_back(mk(0, 32'h12, 3'd1, 32'h0, 0, 0));
        run_queue();

        // Two-wait instance: directed cases
        tgt = 1'b1;
        pend.push_back(mk(1, 32'h20, 3'd2, 32'hCAFEF00D, 0, 0));
        pend.push_back(mk(0, 32'h20, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(0, 32'h21, 3'd1, 32'h0, 0, 0));
        pend.push_back(mk(1, 32'h20, 3'd2, 32'h12345678, 1, 0));
        pend.push_back(mk(0, 32'h20, 3'd2, 32'h0, 0, 0));
        pend.push_back(mk(1, 32'h100, 3'd2, 32'h11111111, 0, 0));
        run_queue();

        // Reset during a wait state of a write: outputs reset, target word keeps old value
        mon_en = 1'b0;
        @(negedge clk);
        drive_addr(mk(1, 32'h100, 3'd2, 32'h22222222, 0, 0));
        @(negedge clk);
        drive_idle(1'b0);
        hwdata = 32'h22222222;
        hwcs   = ref_enc(32'h22222222);
        #1;
        check("ws_stall_before_reset", {31'd0, rdy2}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_hready", {31'd0, rdy2}, 32'd1);
        check("midrst_hresp", {31'd0, rsp2}, 32'd0);
        check("midrst_hrdata", rd2, 32'd0);
        check("midrst_hrcs", {25'd0, rc2}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        pend.push_back(mk(0, 32'h100, 3'd2, 32'h0, 0, 0));
        run_queue();

        // Randomized traffic on both instances
        for (int ti = 0; ti < 2; ti++) begin
            tgt = ti[0];
            for (int w = 0; w < 16; w++) pend.push_back(mk(1, 32'(w * 4), 3'd2, $urandom, 0, 0));
            for (int n = 0; n < 80; n++) begin
                a = 32'($urandom_range(0, 63));
                case ($urandom_range(0, 15))
                    0:       a = 32'h1000 + 32'($urandom_range(0, 255));
                    1:       a = $urandom | 32'h8000_0000;
                    default: ;
                endcase
                t = mk(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 2)), $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) t.size = 3'($urandom_range(3, 7));
                pend.push_back(t);
            end
            run_queue();
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        check("idle_hrdata0", rd0, 32'd0);
        check("idle_hready2", {31'd0, rdy2}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        abort_run("global_timeout");
    end

endmodule
